byte_logic_sequencer: RTL and testbench
=======================================

# byte_logic_sequencer

Sequencer and round-robin arbiter that shares one byte-wide logic datapath (AND, OR, XOR, NOT, any-bit-set, single-bit left shift) between two requesters.
- Multi-bit left shifts are performed iteratively, one single-bit shift per cycle.
- Results return on a valid/ready response channel tagged with the requester ID and a zero flag.
- Sits between the byte logic units and their client blocks.

## Interface
Parameters:
- none; widths fixed (data 8 bits, opcode 3 bits, shift amount `B[2:0]`)

Ports:
- `clk` in 1 — single clock, all state on rising edge
- `rst_n` in 1 — reset, asynchronous, active-low
- `req0_valid` in 1 — requester 0 has an operation
- `req0_ready` out 1 — requester 0 operation accepted this cycle when high with valid
- `req0_op` in 3 — requester 0 opcode
- `req0_a`, `req0_b` in 8 each — requester 0 operands
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b` — same, for requester 1
- `rsp_valid` out 1 — response available
- `rsp_ready` in 1 — consumer accepts response
- `rsp_id` out 1 — requester that issued the response's operation
- `rsp_data` out 8 — result byte
- `rsp_zero` out 1 — high when `rsp_data == 8'h00`

## Operation
Opcodes:
- `000` A&B
- `001` A|B
- `010` A^B
- `011` ~A
- `100` A << `B[2:0]` (logical, zero fill)
- `101` ANYSET: `8'h01` if any bit of A is set, else `8'h00`
- `110` rotate-left (see Configuration)
- `111` illegal: `rsp_data = 8'h00`, `rsp_zero = 1`

States:
- **IDLE**
  - `reqN_ready = (state == IDLE) && (grant == N)`.
  - grant is combinational from the valids and the `rr_last` pointer:
    - single valid wins;
    - if both are valid, the requester not equal to `rr_last` wins.
  - On handshake:
    - latch op, A, `B[2:0]` and ID; set `rr_last = ID`.
    - non-shift op or shift amount 0: compute the result, go to RESP.
    - shift/rotate with k > 0: load A into the work register, load k into the counter, go to EXEC.
- **EXEC**
  - Each cycle, shift the work register left by 1 (rotate: bit 7 feeds bit 0) and decrement the counter.
  - When the counter reaches 1 on the current cycle, write the result and go to RESP.
- **RESP**
  - `rsp_valid = 1`; `rsp_data`, `rsp_id` and `rsp_zero` are stable.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - `reqN_ready` stays 0 in EXEC and RESP.

Boundary conditions:
- `rsp_zero` is derived from the registered `rsp_data` via the any-bit-set reduction, inverted.
- Requester valid may drop without handshake; no state change results.
- Operands are sampled only at the handshake.
- Shift amount 7 on A=`8'hFF` yields `8'h80`.
- Only `B[2:0]` is used; `B[7:3]` is ignored.
- Assertion of `rst_n` mid-EXEC or mid-RESP aborts the operation; no response is issued.

## Timing
- Reset values:
  - state IDLE
  - `rsp_valid = 0`, `rsp_data = 8'h00`, `rsp_id = 0`, `rsp_zero = 1`
  - `rr_last = 1`, so requester 0 wins the first tie
  - `req0_ready` / `req1_ready` follow the grant of IDLE (combinational on the valids)
- Latency, from acceptance edge t:
  - non-shift op or shift amount 0: `rsp_valid` high from cycle t+1
  - shift/rotate by k > 0: `rsp_valid` high from cycle t+1+k
- Throughput:
  - after the response handshake at cycle r, IDLE is entered at r+1 and a new acceptance is possible at r+1.
  - minimum 2 cycles per operation.
- Response backpressure holds RESP indefinitely; outputs remain stable.

## Configuration
- `BYTE_LOGIC_SEQ_ROTATE_EN` defined:
  - opcode `110` = rotate-left A by `B[2:0]`, using the same EXEC iteration with bit 7 wrapping into bit 0.
- Not defined:
  - opcode `110` is illegal, like `111`: 1-cycle latency, `rsp_data = 8'h00`, `rsp_zero = 1`.
  - no rotate logic is present.

## Test plan
- Reset then req0 AND A=`8'hF0` B=`8'h3C` → `rsp_valid` at t+1, `rsp_data = 8'h30`, `rsp_id = 0`, `rsp_zero = 0`.
- req1 SHL A=`8'h81` B=`8'h03` → `rsp_valid` exactly at t+4, `rsp_data = 8'h08`, `rsp_id = 1`; both readies low meanwhile.
- Both valid continuously with XOR A=B=`8'h55`:
  - grants alternate 0,1,0,1;
  - every response has `rsp_data = 8'h00`, `rsp_zero = 1`.
- Hold `rsp_ready = 0` for 5 cycles after an OR response (A=`8'h0F`, B=`8'hF0`):
  - `rsp_data` stays `8'hFF`;
  - no new acceptance occurs;
  - release `rsp_ready` → next acceptance one cycle later.
- ROTATE A=`8'h81` B=`8'h01`:
  - with macro → `8'h03` at t+2;
  - without macro → `8'h00`, `rsp_zero = 1` at t+1.
- Drop `rst_n` during EXEC of a shift by 7 → `rsp_valid` stays 0 and state returns to IDLE; after release, ANYSET A=`8'h00` → `rsp_data = 8'h00`, `rsp_zero = 1`.

Source files
------------

// File: rtl/byte_logic_sequencer.sv
// byte_logic_sequencer
//
// Purpose:
//   Shares one byte-wide logic datapath between two requesters. The datapath
//   supports AND, OR, XOR, NOT, ANYSET and a single-bit left shift. Arbitration
//   between the requesters is round-robin. Multi-bit shifts repeat the
//   single-bit shift once per cycle. Results are returned on a valid/ready
//   response channel, tagged with the requester ID and a zero flag.
//
// Ports:
//   clk                     in   clock, all state on the rising edge
//   rst_n                   in   asynchronous active-low reset
//   req0_valid/req1_valid   in   requester has an operation
//   req0_ready/req1_ready   out  operation accepted when high together with valid
//   req0_op/req1_op         in   [2:0] opcode
//   req0_a/req1_a           in   [7:0] operand A
//   req0_b/req1_b           in   [7:0] operand B (only B[2:0] used by shifts)
//   rsp_valid               out  response available
//   rsp_ready               in   consumer accepts response
//   rsp_id                  out  requester that issued the operation
//   rsp_data                out  [7:0] result byte
//   rsp_zero                out  high when rsp_data == 8'h00
//
// Configuration:
//   BYTE_LOGIC_SEQ_ROTATE_EN  when defined, opcode 3'b110 is rotate-left A by
//                             B[2:0]. Otherwise 3'b110 is illegal, like 3'b111.

module byte_logic_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t     state_r;
  logic       rr_last_r;
  logic [7:0] work_r;
  logic [2:0] cnt_r;
  logic       rsp_valid_r;
  logic       rsp_id_r;
  logic [7:0] rsp_data_r;
`ifdef BYTE_LOGIC_SEQ_ROTATE_EN
  logic       rot_r;
`endif

  logic       grant_s;
  logic [2:0] sel_op_s;
  logic [7:0] sel_a_s;
  logic [7:0] sel_b_s;
  logic       accept_s;
  logic       iter_s;
  logic       rot_s;
  logic [7:0] work_nxt_s;

  // Any-bit-set reduction; shared by the ANYSET opcode and the zero flag.
  function automatic logic anyset8(input logic [7:0] v);
    return |v;
  endfunction

  // Opcodes that run through the EXEC iteration when the amount is non-zero.
  function automatic logic is_iter_op(input logic [2:0] op);
`ifdef BYTE_LOGIC_SEQ_ROTATE_EN
    return (op == 3'b100) || (op == 3'b110);
`else
    return (op == 3'b100);
`endif
  endfunction

  // Single-cycle result. Shift/rotate land here only with amount 0, so the
  // result for them is A unchanged.
  function automatic logic [7:0] direct_result(input logic [2:0] op,
                                               input logic [7:0] a,
                                               input logic [7:0] b);
    logic [7:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~a;
      3'b100:  r = a;
      3'b101:  r = {7'd0, anyset8(a)};
`ifdef BYTE_LOGIC_SEQ_ROTATE_EN
      3'b110:  r = a;
`else
      3'b110:  r = 8'h00;
`endif
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Round-robin grant and operand select: on a tie the requester that was
  // not served last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~rr_last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end

    sel_op_s = req0_op;
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    if (grant_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end

    accept_s = (state_r == ST_IDLE) && (req0_valid || req1_valid);
    iter_s   = is_iter_op(sel_op_s) && (sel_b_s[2:0] != 3'd0);
  end

  // One shift step of the work register; for rotate, bit 7 wraps into bit 0.
  always_comb begin
`ifdef BYTE_LOGIC_SEQ_ROTATE_EN
    rot_s = rot_r;
`else
    rot_s = 1'b0;
`endif
    work_nxt_s = {work_r[6:0], rot_s & work_r[7]};
  end

  assign req0_ready = (state_r == ST_IDLE) && !grant_s;
  assign req1_ready = (state_r == ST_IDLE) &&  grant_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_zero   = ~anyset8(rsp_data_r);

  // Sequencer: accept in IDLE, iterate shifts in EXEC, hold the response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_last_r   <= 1'b1;
      work_r      <= 8'h00;
      cnt_r       <= 3'd0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_data_r  <= 8'h00;
`ifdef BYTE_LOGIC_SEQ_ROTATE_EN
      rot_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            rr_last_r <= grant_s;
            rsp_id_r  <= grant_s;
            if (iter_s) begin
              work_r  <= sel_a_s;
              cnt_r   <= sel_b_s[2:0];
`ifdef BYTE_LOGIC_SEQ_ROTATE_EN
              rot_r   <= (sel_op_s == 3'b110);
`endif
              state_r <= ST_EXEC;
            end else begin
              rsp_data_r  <= direct_result(sel_op_s, sel_a_s, sel_b_s);
              rsp_valid_r <= 1'b1;
              state_r     <= ST_RESP;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          work_r <= work_nxt_s;
          cnt_r  <= cnt_r - 3'd1;
          // Counter at 1 means this is the final step.
          if (cnt_r == 3'd1) begin
            rsp_data_r  <= work_nxt_s;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            state_r <= ST_EXEC;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_logic_sequencer.sv
// tb_byte_logic_sequencer
//
// Drives directed scenarios and a randomized phase into byte_logic_sequencer.
// Each cycle is compared against a transaction-level reference model. The model
// tracks whether an operation is outstanding, how many cycles remain before the
// response appears, the expected result and the round-robin pointer.

module tb_byte_logic_sequencer;

`ifdef BYTE_LOGIC_SEQ_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [2:0] req0_op = 3'd0;
  logic [7:0] req0_a = 8'h00;
  logic [7:0] req0_b = 8'h00;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [2:0] req1_op = 3'd0;
  logic [7:0] req1_a = 8'h00;
  logic [7:0] req1_b = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_zero;

  byte_logic_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit         m_busy = 1'b0;
  int         m_cnt = 0;
  bit         m_rr_last = 1'b1;
  logic [7:0] m_data = 8'h00;
  bit         m_id = 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai;
    int k;
    ai = a;
    k  = b % 8;
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return 8'hFF - a;
      3'd4: return 8'((ai * (1 << k)) % 256);
      3'd5: return (ai != 0) ? 8'h01 : 8'h00;
      3'd6: return ROT ? 8'(((ai * (1 << k)) + (ai / (1 << (8 - k)))) % 256) : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // Extra cycles spent iterating before the response appears.
  function automatic int ref_iters(input logic [2:0] op, input logic [7:0] b);
    if (op == 3'd4 || (ROT && op == 3'd6)) return b % 8;
    return 0;
  endfunction

  function automatic bit ref_grant(input bit v0, input bit v1, input bit rr);
    if (v0 && v1) return !rr;
    return v1;
  endfunction

  // Check the current cycle, advance one clock, update the model.
  task automatic step();
    bit g;
    #1;
    g = ref_grant(req0_valid, req1_valid, m_rr_last);
    check_eq("req0_ready", {7'd0, req0_ready}, {7'd0, (!m_busy && !g)});
    check_eq("req1_ready", {7'd0, req1_ready}, {7'd0, (!m_busy && g)});
    check_eq("rsp_valid", {7'd0, rsp_valid}, {7'd0, (m_busy && m_cnt == 0)});
    if (m_busy && m_cnt == 0) begin
      check_eq("rsp_data", rsp_data, m_data);
      check_eq("rsp_id", {7'd0, rsp_id}, {7'd0, m_id});
      check_eq("rsp_zero", {7'd0, rsp_zero}, {7'd0, (m_data == 8'h00)});
    end
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b0;
      m_rr_last = 1'b1;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        if (rsp_ready) m_busy = 1'b0;
      end else begin
        m_cnt--;
      end
    end else if (req0_valid || req1_valid) begin
      m_id = g;
      m_rr_last = g;
      if (g) begin
        m_data = ref_result(req1_op, req1_a, req1_b);
        m_cnt  = ref_iters(req1_op, req1_b);
      end else begin
        m_data = ref_result(req0_op, req0_a, req0_b);
        m_cnt  = ref_iters(req0_op, req0_b);
      end
      m_busy = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    m_busy = 1'b0;
    m_rr_last = 1'b1;
    #1;
    check_eq("rst_valid", {7'd0, rsp_valid}, 8'h00);
    check_eq("rst_data", rsp_data, 8'h00);
    check_eq("rst_id", {7'd0, rsp_id}, 8'h00);
    check_eq("rst_zero", {7'd0, rsp_zero}, 8'h01);
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Issue one operation from idle and wait (bounded) for its response.
  task automatic run_op(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic z, output int lat);
    drive(id, op, a, b);
    rsp_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    if (lat >= 20) check_eq("rsp_timeout", 8'h00, 8'h01);
    d = rsp_data;
    z = rsp_zero;
    step();
  endtask

  logic [7:0] d;
  logic       z;
  int         lat;
  logic       ids[$];

  initial begin
    do_reset(2);

    run_op(1'b0, 3'b000, 8'hF0, 8'h3C, d, z, lat);
    check_eq("and_data", d, 8'h30);
    check_eq("and_zero", {7'd0, z}, 8'h00);
    check_eq("and_lat", lat[7:0], 8'd1);

    run_op(1'b1, 3'b100, 8'h81, 8'h03, d, z, lat);
    check_eq("shl3_data", d, 8'h08);
    check_eq("shl3_lat", lat[7:0], 8'd4);

    run_op(1'b0, 3'b100, 8'hFF, 8'h07, d, z, lat);
    check_eq("shl7_data", d, 8'h80);
    check_eq("shl7_lat", lat[7:0], 8'd8);

    run_op(1'b1, 3'b100, 8'h01, 8'hF9, d, z, lat);
    check_eq("shl_bhi_data", d, 8'h02);

    run_op(1'b0, 3'b110, 8'h81, 8'h01, d, z, lat);
    check_eq("rot_data", d, ROT ? 8'h03 : 8'h00);
    check_eq("rot_lat", lat[7:0], ROT ? 8'd2 : 8'd1);

    run_op(1'b1, 3'b111, 8'hA5, 8'h5A, d, z, lat);
    check_eq("ill_data", d, 8'h00);
    check_eq("ill_zero", {7'd0, z}, 8'h01);

    run_op(1'b0, 3'b011, 8'h3C, 8'h00, d, z, lat);
    check_eq("not_data", d, 8'hC3);

    // Both requesters continuously valid: grants must alternate.
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 8'h55; req0_b = 8'h55;
    req1_valid = 1'b1; req1_op = 3'b010; req1_a = 8'h55; req1_b = 8'h55;
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid) ids.push_back(rsp_id);
    end
    check_eq("alt_count", {7'd0, (ids.size() >= 4)}, 8'h01);
    for (int i = 1; i < ids.size(); i++)
      check_eq("alt_grant", {7'd0, (ids[i] != ids[i-1])}, 8'h01);

    // Response backpressure after an OR.
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) step();
    drive(1'b0, 3'b001, 8'h0F, 8'hF0);
    rsp_ready = 1'b0;
    step();
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 8'hAA; req1_b = 8'hFF;
    repeat (5) begin
      check_eq("bp_hold", rsp_data, 8'hFF);
      step();
    end
    rsp_ready = 1'b1;
    step();
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step();

    // Reset in the middle of a shift by 7.
    drive(1'b0, 3'b100, 8'hFF, 8'h07);
    step();
    req0_valid = 1'b0;
    repeat (2) step();
    do_reset(2);
    step();
    run_op(1'b1, 3'b101, 8'h00, 8'h00, d, z, lat);
    check_eq("anyset0_data", d, 8'h00);
    check_eq("anyset0_zero", {7'd0, z}, 8'h01);
    run_op(1'b0, 3'b101, 8'h40, 8'h00, d, z, lat);
    check_eq("anyset1_data", d, 8'h01);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom % 2);
      req0_op    = 3'($urandom);
      req0_a     = 8'($urandom);
      req0_b     = 8'($urandom);
      req1_valid = 1'($urandom % 2);
      req1_op    = 3'($urandom);
      req1_a     = 8'($urandom);
      req1_b     = 8'($urandom);
      rsp_ready  = ($urandom % 4) != 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
